// File: rtl/neuron_mac_pkg.sv
// Shared Q6.10 constants, FSM encoding and fixed-point helper for the
// neuron datapath (MAC stage and the downstream sigmoid stage).
package neuron_mac_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam int PROD_W = 2 * DATA_W - FRAC_W;

    localparam logic [DATA_W-1:0] Q_ONE = 16'h0400;
    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    typedef logic [DATA_W-1:0] q_t;

    // Full signed Q6.10 x Q6.10 product, rescaled to Q.10 by an arithmetic
    // shift (floor). All 22 remaining bits are kept, so nothing wraps here.
    function automatic logic signed [PROD_W-1:0] q_mul_raw(input q_t a, input q_t b);
        logic signed [2*DATA_W-1:0] p;
        p = $signed(a) * $signed(b);
        return p[2*DATA_W-1:FRAC_W];
    endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Control, input-stream and output-stream signals of the neuron MAC stage.
// master = the side feeding pairs and consuming the result, slave = the MAC.
interface neuron_mac_if;
    import neuron_mac_pkg::*;

    logic start;
    q_t   bias;
    logic in_valid;
    logic in_ready;
    q_t   x_in;
    q_t   w_in;
    logic out_valid;
    logic out_ready;
    q_t   out_data;
    logic busy;

    modport master (
        output start, bias, in_valid, x_in, w_in, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, bias, in_valid, x_in, w_in, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/neuron_mac_sat_narrow.sv
// Combinational signed saturating narrower, IN_W bits down to Q6.10.
// Also used for the sigmoid input clamp.
module neuron_mac_sat_narrow
    import neuron_mac_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic signed [IN_W-1:0] din,
    output logic [DATA_W-1:0]      dout
);

    // din fits in 16 bits exactly when every bit above bit 14 equals the sign.
    logic in_range;
    assign in_range = (din[IN_W-1:DATA_W-1] == {(IN_W-DATA_W+1){din[IN_W-1]}});

    // Pass through when representable, otherwise clamp toward the sign.
    always_comb begin
        dout = din[DATA_W-1:0];
        if (!in_range) begin
            dout = din[IN_W-1] ? Q_MIN : Q_MAX;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate for one neuron: bias + sum(x*w) over N_IN
// Q6.10 pairs, saturated to Q6.10 and handed downstream on valid/ready.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | waiting for start, bias captured on start
// ST_ACC   | accepting (x, w) beats until N_IN are consumed
// ST_SAT   | one cycle: narrow accumulator into out_data
// ST_OUT   | out_data held until downstream takes it
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int ACC_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    logic [1:0]               state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;
    logic signed [PROD_W-1:0] prod_q;
    logic [DATA_W-1:0]        sat_val;

    assign prod_q       = q_mul_raw(bus.x_in, bus.w_in);
    assign bus.in_ready = (state == ST_ACC);
    assign bus.busy     = (state != ST_IDLE);

    neuron_mac_sat_narrow #(.IN_W(ACC_W)) u_sat (
        .din  (acc),
        .dout (sat_val)
    );

    // Sequencer and datapath registers; the accumulator is wide enough that
    // only the final narrowing can saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            acc           <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc   <= ACC_W'($signed(bus.bias));
                        count <= '0;
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (bus.in_valid) begin
                        acc   <= acc + ACC_W'(prod_q);
                        count <= count + 1'b1;
                        if (count == CNT_LAST) begin
                            state <= ST_SAT;
                        end
                    end
                end
                ST_SAT: begin
                    bus.out_data  <= sat_val;
                    bus.out_valid <= 1'b1;
                    state         <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
